// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential divider.
//   DIV_NBITS_DEF : default operand/result width
//   div_state_e   : divider FSM state encoding (IDLE/RUN/DONE)
package div_pkg;

  localparam int unsigned DIV_NBITS_DEF = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem   in  NBITS  partial remainder
//   quo   in  NBITS  dividend bits still to shift in / quotient bits so far
//   dvs   in  NBITS  divisor
//   rem_n out NBITS  next partial remainder
//   quo_n out NBITS  next quotient/dividend shift register
module div_step
  import div_pkg::*;
#(
  parameter int unsigned NBITS = DIV_NBITS_DEF
) (
  input  logic [NBITS-1:0] rem,
  input  logic [NBITS-1:0] quo,
  input  logic [NBITS-1:0] dvs,
  output logic [NBITS-1:0] rem_n,
  output logic [NBITS-1:0] quo_n
);

  logic [NBITS-1:0] w_trial;
  logic [NBITS:0]   w_diff;
  logic             w_ge;

  always_comb begin
    w_trial = {rem[NBITS-2:0], quo[NBITS-1]};
    // Borrow out of the NBITS+1 subtraction is the compare result.
    w_diff  = {1'b0, w_trial} - {1'b0, dvs};
    // The bit shifted out of rem means the true trial is >= 2^NBITS,
    // which always exceeds dvs; the low bits of w_diff are still exact.
    w_ge    = rem[NBITS-1] | ~w_diff[NBITS];
    rem_n   = w_ge ? w_diff[NBITS-1:0] : w_trial;
    quo_n   = {quo[NBITS-2:0], w_ge};
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider, one quotient bit per clock.
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start_div    in   pulse: capture dividend/divisor, start dividing
//   stop_div     in   pulse: transfer internal result to quotient/rest
//   dividend     in   NBITS operand (sampled on start_div)
//   divisor      in   NBITS operand (sampled on start_div)
//   quotient     out  NBITS registered quotient
//   rest         out  NBITS registered remainder
//   busy_div     out  high while iterating
//   done_div     out  high while an unread result is held
//   div_by_zero  out  result came from a zero divisor
// Build option: define DIVIDE_SIGNED_EN for two's-complement operands
// (truncating division); otherwise unsigned only.
module seq_divider
  import div_pkg::*;
#(
  parameter  int unsigned NBITS = DIV_NBITS_DEF,
  localparam int unsigned CNTW  = $clog2(NBITS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_div,
  input  logic             stop_div,
  input  logic [NBITS-1:0] dividend,
  input  logic [NBITS-1:0] divisor,
  output logic [NBITS-1:0] quotient,
  output logic [NBITS-1:0] rest,
  output logic             busy_div,
  output logic             done_div,
  output logic             div_by_zero
);

  div_state_e       r_state, w_state_n;
  logic [NBITS-1:0] r_rem, r_quo, r_dvs;
  logic [CNTW-1:0]  r_cnt;
  logic             r_dz;
  logic             w_load, w_xfer;
  logic [NBITS-1:0] w_rem_n, w_quo_n;
  logic [NBITS-1:0] w_a_mag, w_b_mag;
  logic [NBITS-1:0] w_q_out, w_r_out;

  div_step #(.NBITS(NBITS)) u_step (
    .rem   (r_rem),
    .quo   (r_quo),
    .dvs   (r_dvs),
    .rem_n (w_rem_n),
    .quo_n (w_quo_n)
  );

`ifdef DIVIDE_SIGNED_EN
  logic r_a_neg, r_b_neg;

  // Iterate on magnitudes; signs are reapplied on transfer.
  always_comb begin
    w_a_mag = dividend[NBITS-1] ? (~dividend + NBITS'(1)) : dividend;
    w_b_mag = divisor[NBITS-1]  ? (~divisor  + NBITS'(1)) : divisor;
    // A zero divisor keeps the raw all-ones quotient regardless of sign.
    w_q_out = ((r_a_neg ^ r_b_neg) && !r_dz) ? (~r_quo + NBITS'(1)) : r_quo;
    w_r_out = r_a_neg ? (~r_rem + NBITS'(1)) : r_rem;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
    end else if (w_load) begin
      r_a_neg <= dividend[NBITS-1];
      r_b_neg <= divisor[NBITS-1];
    end
  end
`else
  always_comb begin
    w_a_mag = dividend;
    w_b_mag = divisor;
    w_q_out = r_quo;
    w_r_out = r_rem;
  end
`endif

  // Next-state / control decode.
  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_xfer    = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        w_xfer = stop_div;
        if (start_div) begin
          w_state_n = DIV_RUN;
          w_load    = 1'b1;
        end
      end
      DIV_RUN: begin
        if (start_div) begin
          w_load = 1'b1;
        end else if (r_cnt == CNTW'(1)) begin
          w_state_n = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (stop_div) begin
          w_xfer    = 1'b1;
          w_state_n = DIV_IDLE;
        end
        if (start_div) begin
          w_state_n = DIV_RUN;
          w_load    = 1'b1;
        end
      end
      default: w_state_n = DIV_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= DIV_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_dz        <= 1'b0;
      quotient    <= '0;
      rest        <= '0;
      busy_div    <= 1'b0;
      done_div    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      busy_div <= (w_state_n == DIV_RUN);
      done_div <= (w_state_n == DIV_DONE);
      if (w_load) begin
        r_rem <= '0;
        r_quo <= w_a_mag;
        r_dvs <= w_b_mag;
        r_dz  <= (divisor == '0);
        r_cnt <= CNTW'(NBITS);
      end else if (r_state == DIV_RUN) begin
        r_rem <= w_rem_n;
        r_quo <= w_quo_n;
        r_cnt <= r_cnt - CNTW'(1);
      end
      // Transfer reads the pre-load result, so start+stop in DONE hands over the old one.
      if (w_xfer) begin
        quotient    <= w_q_out;
        rest        <= w_r_out;
        div_by_zero <= r_dz;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_div, stop_div;
  logic [31:0] dividend, divisor;
  logic [31:0] quotient, rest;
  logic        busy_div, done_div, div_by_zero;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_q, last_r;
  logic        last_dz;
  int          bc;

  seq_divider #(.NBITS(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_div   (start_div),
    .stop_div    (stop_div),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .rest        (rest),
    .busy_div    (busy_div),
    .done_div    (done_div),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else begin
`ifdef DIVIDE_SIGNED_EN
      longint la, lb;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      e.q = 32'(la / lb); e.r = 32'(la % lb);
`else
      e.q = a / b; e.r = a % b;
`endif
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    dividend  = a;
    divisor   = b;
    start_div = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clock);
    start_div = 1'b0;
    dividend  = $urandom();
    divisor   = $urandom();
  endtask

  task automatic wait_done(input string tag, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_div) break;
      if (busy_div) busy_cycles++;
      @(negedge clock);
    end
    chk({tag, "_done"}, 32'(done_div), 32'd1);
  endtask

  task automatic stop_op(input string tag);
    exp_t e;
    stop_div = 1'b1;
    @(negedge clock);
    stop_div = 1'b0;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, rest, e.r);
      chk({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
      last_q = e.q; last_r = e.r; last_dz = e.dz;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    start_op(a, b);
    wait_done(tag, bc);
    stop_op(tag);
  endtask

  initial begin
    reset = 1'b0; start_div = 1'b0; stop_div = 1'b0;
    dividend = '0; divisor = '0;
    #23;
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", rest, 32'd0);
    chk("rst_busy", 32'(busy_div), 32'd0);
    chk("rst_done", 32'(done_div), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // 100/7 with busy-length check
    start_op(32'd100, 32'd7);
    wait_done("d100_7", bc);
    chk("d100_7_busy_cnt", 32'(bc), 32'd32);
    stop_op("d100_7");
    chk("d100_7_done_clr", 32'(done_div), 32'd0);
    chk("d100_7_busy_clr", 32'(busy_div), 32'd0);

    // stop in IDLE re-copies the held result
    stop_div = 1'b1;
    @(negedge clock);
    stop_div = 1'b0;
    chk("idle_stop_q", quotient, last_q);
    chk("idle_stop_r", rest, last_r);

    run_op("d7_100", 32'd7, 32'd100);
    run_op("dmax_1", 32'hFFFF_FFFF, 32'd1);
    run_op("d25_0", 32'd25, 32'd0);
    run_op("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // restart mid-run; a stop during RUN is ignored
    start_op(32'd1000, 32'd3);
    repeat (4) @(negedge clock);
    stop_div = 1'b1;
    @(negedge clock);
    stop_div = 1'b0;
    chk("run_stop_q", quotient, last_q);
    chk("run_stop_busy", 32'(busy_div), 32'd1);
    repeat (4) @(negedge clock);
    void'(sb.pop_back());
    start_op(32'd50, 32'd5);
    wait_done("restart", bc);
    chk("restart_busy_cnt", 32'(bc), 32'd32);
    stop_op("restart");

    // start+stop together in DONE: old result transferred, new run begins
    start_op(32'd1234, 32'd10);
    wait_done("d1234_10", bc);
    stop_div = 1'b1;
    start_op(32'd99, 32'd9);
    stop_div = 1'b0;
    begin
      exp_t e;
      e = sb.pop_front();
      chk("both_q", quotient, e.q);
      chk("both_r", rest, e.r);
    end
    chk("both_busy", 32'(busy_div), 32'd1);
    wait_done("d99_9", bc);
    stop_op("d99_9");

    // reset mid-run aborts the division
    start_op(32'd77, 32'd3);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", rest, 32'd0);
    chk("arst_busy", 32'(busy_div), 32'd0);
    chk("arst_done", 32'(done_div), 32'd0);
    void'(sb.pop_back());
    @(negedge clock);
    reset = 1'b1;
    stop_div = 1'b1;
    @(negedge clock);
    stop_div = 1'b0;
    chk("arst_stop_q", quotient, 32'd0);
    chk("arst_stop_r", rest, 32'd0);

`ifdef DIVIDE_SIGNED_EN
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2);
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE);
    run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("s_m25_0", 32'hFFFF_FFE7, 32'd0);
`endif

    for (int i = 0; i < 4; i++) begin
      run_op("rand", $urandom(), 32'($urandom_range(1, 100000)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
